// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter: port 0 (core) has priority, and port 1 (debug/DMA)
// is promoted after STARVE_LIMIT denied cycles. Read data returns one cycle after its grant.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic [DATA_W-1:0] o_rdata0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] o_starve_cnt
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Handshake: a requester holds req/we/addr/wdata until it sees its gnt; the access
    // completes in that gnt cycle and a new access may be presented the next cycle.

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_tag_valid;
    logic             r_tag_port;

    logic w_promote;
    logic w_gnt0;
    logic w_gnt1;
    logic w_we;

    always_comb begin
        w_promote = (r_starve_cnt == LIMIT) && i_req1;
        w_gnt1    = i_reset && i_req1 && (w_promote || !i_req0);
        w_gnt0    = i_reset && i_req0 && !w_gnt1;
        w_we      = w_gnt1 ? i_we1 : i_we0;
    end

    always_comb begin
        o_gnt0      = w_gnt0;
        o_gnt1      = w_gnt1;
        o_mem_rd    = (w_gnt0 || w_gnt1) && !w_we;
        o_mem_wr    = (w_gnt0 || w_gnt1) && w_we;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt1) begin
            o_mem_addr  = i_addr1;
            o_mem_wdata = i_wdata1;
        end else if (w_gnt0) begin
            o_mem_addr  = i_addr0;
            o_mem_wdata = i_wdata0;
        end
    end

    // The return is also gated by reset so a read granted just before reset is dropped.
    always_comb begin
        o_rvalid0 = i_reset && r_tag_valid && !r_tag_port;
        o_rvalid1 = i_reset && r_tag_valid && r_tag_port;
        o_rdata0  = o_rvalid0 ? i_mem_rdata : '0;
        o_rdata1  = o_rvalid1 ? i_mem_rdata : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_starve_cnt <= '0;
            r_tag_valid  <= 1'b0;
            r_tag_port   <= 1'b0;
        end else begin
            if (!i_req1 || w_gnt1) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            r_tag_valid <= o_mem_rd;
            r_tag_port  <= w_gnt1;
        end
    end

    assign o_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: inputs change 1ns after each rising edge,
// outputs are sampled 1ns later, well clear of the next edge.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [2:0]        starve_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rvalid0), .o_rdata0(rdata0),
        .o_rvalid1(rvalid1), .o_rdata1(rdata1),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_rdata = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return {gnt0, gnt1, mem_rd, mem_wr, rvalid0, rvalid1, 22'(mem_addr)} | 64'(mem_wdata)
               | 64'(rdata0) | 64'(rdata1);
    endfunction

    initial begin
        reset = 0;
        clear_inputs();
        next_cycle();
        next_cycle();
        // Requests while in reset must not be granted.
        req0 = 1; req1 = 1; addr0 = 10'h0AA; wdata0 = 32'h1234;
        #1;
        check("reset_outputs", all_outs(), 64'h0);
        next_cycle();
        reset = 1;
        clear_inputs();
        #1;
        check("post_reset_cnt", 64'(starve_cnt), 64'd0);
        check("post_reset_idle", all_outs(), 64'h0);

        // Single read on port 0.
        req0 = 1; we0 = 0; addr0 = 10'h005;
        #1;
        check("rd_gnt0", {gnt0, gnt1, mem_rd, mem_wr}, 4'b1010);
        check("rd_addr", 64'(mem_addr), 64'h005);
        next_cycle();
        req0 = 0; mem_rdata = 32'h0000_00AA;
        #1;
        check("rd_rvalid", {rvalid0, rvalid1}, 2'b10);
        check("rd_rdata0", 64'(rdata0), 64'hAA);
        check("rd_rdata1_zero", 64'(rdata1), 64'h0);
        next_cycle();
        mem_rdata = 32'h5555_5555;
        #1;
        check("rd_rvalid_one_cycle", {rvalid0, rvalid1, 64'(rdata0)}, 64'h0);

        // Write on port 1.
        req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 32'hDEAD_BEEF;
        #1;
        check("wr_gnt1", {gnt0, gnt1, mem_rd, mem_wr}, 4'b0101);
        check("wr_addr", 64'(mem_addr), 64'h3FF);
        check("wr_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        next_cycle();
        clear_inputs(); mem_rdata = 32'h1234_5678;
        #1;
        check("wr_no_rvalid", {rvalid0, rvalid1, 64'(rdata0 | rdata1)}, 64'h0);

        // Starvation: both held; port 1 wins on the fifth cycle.
        req0 = 1; req1 = 1; we0 = 0; we1 = 1; addr0 = 10'h001; addr1 = 10'h002;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] exp_cnt;
            exp_cnt = (i == 5) ? 3'd0 : 3'(i);
            #1;
            check($sformatf("starve_gnt_c%0d", i + 1), {gnt0, gnt1}, (i == 4) ? 2'b01 : 2'b10);
            check($sformatf("starve_cnt_c%0d", i + 1), 64'(starve_cnt), 64'(exp_cnt));
            next_cycle();
        end
        clear_inputs();
        next_cycle();

        // Pipelined alternating reads.
        req0 = 1; we0 = 0; addr0 = 10'h010;
        #1;
        check("alt_rd0_issue", {gnt0, mem_rd, 10'(mem_addr)}, {2'b11, 10'h010});
        next_cycle();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 10'h020; mem_rdata = 32'h1111_0010;
        #1;
        check("alt_rd1_issue", {gnt1, mem_rd, 10'(mem_addr)}, {2'b11, 10'h020});
        check("alt_rvalid0", {rvalid0, rvalid1}, 2'b10);
        check("alt_rdata0", 64'(rdata0), 64'h1111_0010);
        next_cycle();
        req1 = 0; mem_rdata = 32'h2222_0020;
        #1;
        check("alt_rvalid1", {rvalid0, rvalid1}, 2'b01);
        check("alt_rdata1", 64'(rdata1), 64'h2222_0020);
        check("alt_rdata0_zero", 64'(rdata0), 64'h0);
        next_cycle();

        // Write right after a read leaves the read return intact.
        clear_inputs();
        req0 = 1; addr0 = 10'h007;
        next_cycle();
        req0 = 0; req1 = 1; we1 = 1; addr1 = 10'h008; wdata1 = 32'hCAFE_0008; mem_rdata = 32'h77;
        #1;
        check("rw_mem_wr", {mem_rd, mem_wr, gnt1}, 3'b011);
        check("rw_rdata0", {rvalid0, rvalid1, 64'(rdata0)}, {2'b10, 64'h77});
        next_cycle();
        clear_inputs();
        #1;
        check("rw_no_second_rvalid", {rvalid0, rvalid1}, 2'b00);

        // Reset mid-read with a non-zero starvation count.
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 10'h033; addr1 = 10'h044;
        next_cycle();
        #1;
        check("mid_pre_cnt", 64'(starve_cnt), 64'd1);
        check("mid_gnt0", {gnt0, mem_rd}, 2'b11);
        next_cycle();
        reset = 0; mem_rdata = 32'h99;
        #1;
        check("mid_reset_outputs", all_outs(), 64'h0);
        next_cycle();
        reset = 1; req0 = 0; req1 = 0;
        #1;
        check("mid_after_cnt", 64'(starve_cnt), 64'd0);
        check("mid_after_rvalid", {rvalid0, rvalid1, 64'(rdata0)}, 64'h0);

        // Idle.
        clear_inputs(); mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check($sformatf("idle_c%0d", i), all_outs(), 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
